// File: rtl/minas_pkg.sv
// minas_pkg: shared state encoding and neighbour offset table for the mine scanner
package minas_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} scan_state_t;
  localparam logic signed [1:0] NBR_DX [8] = '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};
  localparam logic signed [1:0] NBR_DY [8] = '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
endpackage

// File: rtl/mine_cell_lookup.sv
// mine_cell_lookup: reads one cell of a mine grid from signed coordinates, with range check or toroidal wrap
module mine_cell_lookup #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int WRAP = 0,
  parameter int W = 9
) (
  input  logic signed [W-1:0]      row,
  input  logic signed [W-1:0]      col,
  input  logic [ROWS-1:0][COLS-1:0] grid,
  output logic                     mine
);
  logic signed [31:0] r, c;
  logic ok;
  logic [ROWS*COLS-1:0] sh;
  always_comb begin
    r = 32'(row);
    c = 32'(col);
    // neighbour coordinates only ever step one past an edge, so a single add/subtract is a full mod
    if (WRAP != 0) begin
      r = r < 0 ? r + ROWS : (r >= ROWS ? r - ROWS : r);
      c = c < 0 ? c + COLS : (c >= COLS ? c - COLS : c);
    end
    ok = r >= 0 && r < ROWS && c >= 0 && c < COLS;
    sh = grid >> (ok ? r * COLS + c : 0);
    mine = ok & sh[0];
  end
endmodule

// File: rtl/mine_neighbour_scanner.sv
// mine_neighbour_scanner: checks one grid cell for a mine and counts mined neighbours, one neighbour per clock
module mine_neighbour_scanner
  import minas_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int COORD_W = 8,
  parameter int WRAP = 0,
  parameter int EARLY_EXIT = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic [COORD_W-1:0]        x,
  input  logic [COORD_W-1:0]        y,
  input  logic [ROWS-1:0][COLS-1:0] grid_mines_in,
  output logic                      busy,
  output logic                      valid,
  output logic                      bomb,
  output logic                      in_range,
  output logic [3:0]                adj_count
);
  localparam int W = COORD_W + 1;
  scan_state_t state, nxt;
  logic [COORD_W-1:0] cx, cy;
  logic [ROWS-1:0][COLS-1:0] snap;
  logic [2:0] k;
  logic [3:0] acc;
  logic c_in, c_bomb, centre_in, centre_mine, nbr, skip, fin;
  logic signed [W-1:0] nr, nc;
  assign centre_in = 32'(cx) < ROWS && 32'(cy) < COLS;
  assign nr = $signed({1'b0, cx}) + W'(NBR_DX[k]);
  assign nc = $signed({1'b0, cy}) + W'(NBR_DY[k]);
  // the centre verdict is registered in CHECK, so an early exit leaves from the first SCAN cycle
  assign skip = !c_in || (EARLY_EXIT != 0 && c_bomb);
  assign fin = state == SCAN && (skip || k == 3'd7);
  assign busy = state != IDLE;
  mine_cell_lookup #(.ROWS(ROWS), .COLS(COLS), .WRAP(WRAP), .W(W)) u_centre (
    .row($signed({1'b0, cx})), .col($signed({1'b0, cy})), .grid(snap), .mine(centre_mine)
  );
  mine_cell_lookup #(.ROWS(ROWS), .COLS(COLS), .WRAP(WRAP), .W(W)) u_nbr (
    .row(nr), .col(nc), .grid(snap), .mine(nbr)
  );
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (req ? CHECK : IDLE) : state == CHECK ? SCAN : state == SCAN ? (fin ? DONE : SCAN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cx <= '0;
      cy <= '0;
      snap <= '0;
      k <= '0;
      acc <= '0;
      c_in <= 1'b0;
      c_bomb <= 1'b0;
      valid <= 1'b0;
      bomb <= 1'b0;
      in_range <= 1'b0;
      adj_count <= '0;
    end else begin
      state <= nxt;
      valid <= fin;
      if (state == IDLE && req) begin
        cx <= x;
        cy <= y;
        snap <= grid_mines_in;
        k <= '0;
        acc <= '0;
      end
      if (state == CHECK) begin
        c_in <= centre_in;
        c_bomb <= centre_in & centre_mine;
      end
      if (state == SCAN) begin
        k <= k + 3'd1;
        acc <= acc + {3'b0, nbr};
      end
      if (fin) begin
        bomb <= c_bomb;
        in_range <= c_in;
        adj_count <= skip ? 4'd0 : acc + {3'b0, nbr};
      end
    end
  end
endmodule

// File: tb/tb_mine_neighbour_scanner.sv
// tb_mine_neighbour_scanner: four parameter variants driven together and checked against a grid-level model
module tb_mine_neighbour_scanner;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0;
  logic [7:0] x = '0, y = '0;
  logic [7:0][7:0] grid8 = '0;
  logic [15:0][9:0] grid16 = '0;
  logic busy[4], valid[4], bomb[4], inr[4];
  logic [3:0] adj[4];
  bit g[16][16];
  int checks = 0, failures = 0;
  logic gb[4], gi[4];
  logic [3:0] ga[4];
  int gl[4], nv[4];
  always #5 clk = ~clk;
  // d0: 8x8 plain, d1: 8x8 wrap, d2: 8x8 early exit, d3: 16x10 wrap
  mine_neighbour_scanner #(.ROWS(8), .COLS(8), .COORD_W(8), .WRAP(0), .EARLY_EXIT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .x(x), .y(y), .grid_mines_in(grid8),
    .busy(busy[0]), .valid(valid[0]), .bomb(bomb[0]), .in_range(inr[0]), .adj_count(adj[0]));
  mine_neighbour_scanner #(.ROWS(8), .COLS(8), .COORD_W(8), .WRAP(1), .EARLY_EXIT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .x(x), .y(y), .grid_mines_in(grid8),
    .busy(busy[1]), .valid(valid[1]), .bomb(bomb[1]), .in_range(inr[1]), .adj_count(adj[1]));
  mine_neighbour_scanner #(.ROWS(8), .COLS(8), .COORD_W(8), .WRAP(0), .EARLY_EXIT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req), .x(x), .y(y), .grid_mines_in(grid8),
    .busy(busy[2]), .valid(valid[2]), .bomb(bomb[2]), .in_range(inr[2]), .adj_count(adj[2]));
  mine_neighbour_scanner #(.ROWS(16), .COLS(10), .COORD_W(8), .WRAP(1), .EARLY_EXIT(0)) u3 (
    .clk(clk), .rst_n(rst_n), .req(req), .x(x), .y(y), .grid_mines_in(grid16),
    .busy(busy[3]), .valid(valid[3]), .bomb(bomb[3]), .in_range(inr[3]), .adj_count(adj[3]));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int d, input int cx, input int cy,
                                output logic b, output logic ir, output logic [3:0] a, output int lat);
    int rows = d == 3 ? 16 : 8;
    int cols = d == 3 ? 10 : 8;
    bit wrap = d == 1 || d == 3;
    bit early = d == 2;
    int n = 0;
    ir = cx < rows && cy < cols;
    b = ir && g[cx][cy];
    if (ir && !(early && b))
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++) begin
          int r = cx + dr, c = cy + dc;
          if (dr == 0 && dc == 0) continue;
          if (wrap) begin
            r = (r + rows) % rows;
            c = (c + cols) % cols;
          end
          if (r >= 0 && r < rows && c >= 0 && c < cols && g[r][c]) n++;
        end
    a = 4'(n);
    lat = (ir && !(early && b)) ? 9 : 2;
  endfunction

  task automatic load();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 10; c++) begin
        grid16[r][c] = g[r][c];
        if (r < 8 && c < 8) grid8[r][c] = g[r][c];
      end
  endtask

  task automatic clr();
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) g[r][c] = 1'b0;
  endtask

  task automatic randg();
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) g[r][c] = $urandom_range(0, 3) == 0;
  endtask

  task automatic run(input int xi, input int yi, input bit scr, input string tag);
    logic eb[4], ei[4];
    logic [3:0] ea[4];
    int el[4];
    for (int d = 0; d < 4; d++) begin
      model(d, xi, yi, eb[d], ei[d], ea[d], el[d]);
      nv[d] = 0;
      gl[d] = -1;
    end
    @(negedge clk);
    x = 8'(xi);
    y = 8'(yi);
    load();
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    if (scr) begin
      randg();
      load();
    end
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
        if (e == 1) chk($sformatf("%s_d%0d_busy", tag, d), int'(busy[d]), 1);
        if (valid[d]) begin
          nv[d]++;
          gl[d] = e;
          gb[d] = bomb[d];
          gi[d] = inr[d];
          ga[d] = adj[d];
        end
      end
    end
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_d%0d_nvalid", tag, d), nv[d], 1);
      chk($sformatf("%s_d%0d_latency", tag, d), gl[d], el[d]);
      chk($sformatf("%s_d%0d_bomb", tag, d), int'(gb[d]), int'(eb[d]));
      chk($sformatf("%s_d%0d_in_range", tag, d), int'(gi[d]), int'(ei[d]));
      chk($sformatf("%s_d%0d_adj", tag, d), int'(ga[d]), int'(ea[d]));
    end
  endtask

  initial begin
    int cnt;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset_d%0d_busy", d), int'(busy[d]), 0);
      chk($sformatf("reset_d%0d_valid", d), int'(valid[d]), 0);
      chk($sformatf("reset_d%0d_bomb", d), int'(bomb[d]), 0);
      chk($sformatf("reset_d%0d_in_range", d), int'(inr[d]), 0);
      chk($sformatf("reset_d%0d_adj", d), int'(adj[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    g[3][3] = 1; g[2][2] = 1; g[4][4] = 1;
    run(3, 3, 0, "interior");
    chk("interior_spec_adj", int'(ga[0]), 2);
    chk("interior_spec_latency", gl[0], 9);
    clr();
    g[0][1] = 1; g[1][0] = 1; g[1][1] = 1; g[7][7] = 1;
    run(0, 0, 0, "corner");
    chk("corner_nowrap_spec_adj", int'(ga[0]), 3);
    chk("corner_wrap_spec_adj", int'(ga[1]), 4);
    run(8, 2, 0, "oor");
    chk("oor_spec_latency", gl[0], 2);
    clr();
    for (int r = 4; r <= 6; r++) for (int c = 4; c <= 6; c++) g[r][c] = 1;
    run(5, 5, 0, "early");
    chk("early_spec_adj", int'(ga[2]), 0);
    chk("full_spec_adj", int'(ga[0]), 8);
    clr();
    g[14][8] = 1; g[15][8] = 1;
    run(15, 9, 0, "sweep");
    chk("sweep_spec_adj", int'(ga[3]), 2);
    randg();
    run(4, 4, 1, "snapshot");
    for (int i = 0; i < 20; i++) begin
      randg();
      run($urandom_range(0, 17), $urandom_range(0, 11), i[0], $sformatf("rand%0d", i));
    end
    // req held high: one result, then a fresh accept after DONE is left
    clr();
    g[1][1] = 1;
    @(negedge clk);
    x = 8'd2; y = 8'd2;
    load();
    req = 1'b1;
    @(posedge clk);
    cnt = 0;
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk);
      #1;
      if (e <= 10 && valid[0]) cnt++;
      if (e == 10) chk("held_idle_busy", int'(busy[0]), 0);
      if (e == 11) chk("held_reaccept_busy", int'(busy[0]), 1);
    end
    chk("held_nvalid", cnt, 1);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // reset while the scan is at k=4
    randg();
    @(negedge clk);
    x = 8'd3; y = 8'd3;
    load();
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_pre_busy", int'(busy[0]), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("midrst_d%0d_busy", d), int'(busy[d]), 0);
      chk($sformatf("midrst_d%0d_valid", d), int'(valid[d]), 0);
      chk($sformatf("midrst_d%0d_bomb", d), int'(bomb[d]), 0);
      chk($sformatf("midrst_d%0d_in_range", d), int'(inr[d]), 0);
      chk($sformatf("midrst_d%0d_adj", d), int'(adj[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (valid[0]) cnt++;
    end
    chk("midrst_no_valid", cnt, 0);
    randg();
    run(3, 3, 0, "after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
